// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the RAM port arbiter.
package ram_arb_pkg;

    // Widest requester count supported; tag ids are sized for it.
    localparam int unsigned MaxReq = 8;
    localparam int unsigned IdW    = 3;

    typedef enum logic [0:0] {
        StIdle,
        StOwn
    } arb_state_e;

    typedef struct packed {
        logic           valid;
        logic [IdW-1:0] id;
    } rd_tag_t;

    // One-hot round-robin pick among the first num bits of req, starting after last.
    function automatic logic [MaxReq-1:0] rr_pick(input logic [MaxReq-1:0] req,
                                                  input logic [IdW-1:0]    last,
                                                  input int unsigned       num);
        logic [MaxReq-1:0] pick;
        int unsigned       idx;
        pick = '0;
        for (int unsigned k = 1; k <= MaxReq; k++) begin
            idx = (32'(last) + k) % num;
            if (k <= num && pick == '0 && req[idx[IdW-1:0]]) begin
                pick[idx[IdW-1:0]] = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/ram_arb_rd_track.sv
// Read-tag pipeline: follows each issued read for RD_LAT cycles, then strobes its issuer.
module ram_arb_rd_track
    import ram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned RD_LAT  = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push_i,
    input  logic [IdW-1:0]     push_id_i,
    output logic [NUM_REQ-1:0] rvalid_o,
    output logic               pending_o
);

    rd_tag_t pipe_q [RD_LAT];

    // Shift tags one stage per cycle; reset drops every in-flight read.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= '{valid: push_i, id: push_id_i};
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // Decode the tail tag to a one-hot return strobe and flag any read in flight.
    always_comb begin
        rvalid_o  = '0;
        pending_o = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rvalid_o[i] = pipe_q[RD_LAT-1].valid && (pipe_q[RD_LAT-1].id == IdW'(i));
        end
        for (int i = 0; i < RD_LAT; i++) begin
            pending_o = pending_o | pipe_q[i].valid;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM among NUM_REQ requesters.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned AW        = 10,
    parameter int unsigned DW        = 32,
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_i,
    input  logic [NUM_REQ-1:0]    lock_i,
    input  logic [NUM_REQ-1:0]    we_i,
    input  logic [NUM_REQ*AW-1:0] addr_i,
    input  logic [NUM_REQ*DW-1:0] wdata_i,
    output logic [NUM_REQ-1:0]    gnt_o,
    output logic [NUM_REQ-1:0]    rvalid_o,
    output logic [DW-1:0]         rdata_o,
    input  logic                  ram_ready_i,
    output logic                  ram_en_o,
    output logic                  ram_we_o,
    output logic [AW-1:0]         ram_addr_o,
    output logic [DW-1:0]         ram_wdata_o,
    input  logic [DW-1:0]         ram_rdata_i,
    output logic                  busy_o
);

    localparam int unsigned CntW = 5;

    arb_state_e      state_q;
    logic [IdW-1:0]  last_q;
    logic [CntW-1:0] burst_q;
    logic            ram_en_q;
    logic            ram_we_q;
    logic [AW-1:0]   ram_addr_q;
    logic [DW-1:0]   ram_wdata_q;
    logic [IdW-1:0]  ram_id_q;

    logic [MaxReq-1:0]  rr_full;
    logic [NUM_REQ-1:0] owner_oh;
    logic [NUM_REQ-1:0] gnt;
    logic               owner_req;
    logic               owner_lock;
    logic               accept;
    logic               sel_we;
    logic               sel_lock;
    logic [AW-1:0]      sel_addr;
    logic [DW-1:0]      sel_wdata;
    logic [IdW-1:0]     sel_id;
    logic [CntW-1:0]    burst_inc;
    logic               rd_pending;
    logic               unused_rr;

    assign rr_full   = rr_pick(MaxReq'(req_i), last_q, NUM_REQ);
    assign unused_rr = ^rr_full;
    assign burst_inc = burst_q + 1'b1;

    // Grant: owner-only while locked, round-robin otherwise; nothing while the RAM stalls.
    always_comb begin
        owner_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            owner_oh[i] = (last_q == IdW'(i));
        end
        owner_req  = |(req_i & owner_oh);
        owner_lock = |(lock_i & owner_oh);
        gnt = '0;
        if (!rst && ram_ready_i) begin
            if (state_q == StOwn) begin
                gnt = owner_oh & req_i;
            end else begin
                gnt = rr_full[NUM_REQ-1:0];
            end
        end
        accept = |gnt;
    end

    // Mux the winning requester's command fields.
    always_comb begin
        sel_we    = 1'b0;
        sel_lock  = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_we    = we_i[i];
                sel_lock  = lock_i[i];
                sel_addr  = addr_i[i*AW +: AW];
                sel_wdata = wdata_i[i*DW +: DW];
                sel_id    = IdW'(i);
            end
        end
    end

    // Arbitration FSM plus the registered RAM command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            last_q      <= IdW'(NUM_REQ - 1);
            burst_q     <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_id_q    <= '0;
        end else begin
            ram_en_q <= accept;
            if (accept) begin
                ram_we_q    <= sel_we;
                ram_addr_q  <= sel_addr;
                ram_wdata_q <= sel_wdata;
                ram_id_q    <= sel_id;
            end
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        last_q  <= sel_id;
                        burst_q <= CntW'(1);
                        // A burst limit of one already exhausts the lock on the first grant.
                        if (sel_lock && BURST_MAX > 1) begin
                            state_q <= StOwn;
                        end
                    end
                end
                StOwn: begin
                    if (!owner_req) begin
                        state_q <= StIdle;
                    end else if (accept) begin
                        burst_q <= burst_inc;
                        // last_q stays on the owner, so a forced exit resumes at owner+1.
                        if (!owner_lock || burst_inc >= CntW'(BURST_MAX)) begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    ram_arb_rd_track #(
        .NUM_REQ (NUM_REQ),
        .RD_LAT  (RD_LAT)
    ) u_rd_track (
        .clk_i     (clk),
        .rst_i     (rst),
        .push_i    (ram_en_q & ~ram_we_q),
        .push_id_i (ram_id_q),
        .rvalid_o  (rvalid_o),
        .pending_o (rd_pending)
    );

    assign gnt_o       = gnt;
    assign ram_en_o    = ram_en_q;
    assign ram_we_o    = ram_we_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_wdata_o = ram_wdata_q;
    assign rdata_o     = (|rvalid_o) ? ram_rdata_i : '0;
    assign busy_o      = (state_q == StOwn) | rd_pending;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomised and directed bench for ram_port_arbiter against a transaction-level model.
module tb_ram_port_arbiter;

    localparam int N     = 4;
    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int RDL   = 2;
    localparam int BMAX  = 4;
    localparam int DEPTH = 1 << AW;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_i, lock_i, we_i;
    logic [N*AW-1:0] addr_i;
    logic [N*DW-1:0] wdata_i;
    logic [N-1:0]    gnt_o, rvalid_o;
    logic [DW-1:0]   rdata_o;
    logic            ram_ready_i;
    logic            ram_en_o, ram_we_o;
    logic [AW-1:0]   ram_addr_o;
    logic [DW-1:0]   ram_wdata_o;
    logic [DW-1:0]   ram_rdata_i;
    logic            busy_o;

    ram_port_arbiter #(
        .NUM_REQ   (N),
        .AW        (AW),
        .DW        (DW),
        .RD_LAT    (RDL),
        .BURST_MAX (BMAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .lock_i      (lock_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .ram_ready_i (ram_ready_i),
        .ram_en_o    (ram_en_o),
        .ram_we_o    (ram_we_o),
        .ram_addr_o  (ram_addr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata_i),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Bench-side RAM that answers the DUT's command port.
    logic [DW-1:0] ram_mem [DEPTH];
    logic [DW-1:0] ram_pipe [RDL];

    // Reference model: ownership, round-robin pointer, expected command, outstanding reads.
    typedef struct {
        int            due;
        int            acc;
        int            id;
        logic [DW-1:0] data;
    } rd_t;

    logic [DW-1:0] ref_mem [DEPTH];
    rd_t           rq[$];
    int            owner, last_g, cnt, cyc;
    logic          exp_en, exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic [N-1:0]  saved_gnt;

    logic          s_en, s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [N-1:0]  seen_gnt, seen_rv;
    logic [DW-1:0] seen_rd;
    logic          seen_en, seen_we, seen_busy;

    task automatic model_reset();
        owner = -1;
        last_g = N - 1;
        cnt = 0;
        exp_en = 1'b0;
        exp_we = 1'b0;
        exp_addr = '0;
        exp_wdata = '0;
        rq.delete();
    endtask

    function automatic logic [N-1:0] model_gnt();
        logic [N-1:0] g;
        g = '0;
        if (rst || !ram_ready_i) return g;
        if (owner >= 0) begin
            if (req_i[owner]) g[owner] = 1'b1;
            return g;
        end
        for (int k = 1; k <= N; k++) begin
            int n;
            n = (last_g + k) % N;
            if (req_i[n]) begin
                g[n] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    task automatic check_outputs();
        logic [N-1:0]  g, exp_rv;
        logic [DW-1:0] exp_rd;
        logic          exp_busy;
        g = model_gnt();
        saved_gnt = g;
        check_eq("gnt", gnt_o, g);
        check_eq("ram_en", ram_en_o, exp_en);
        check_eq("ram_we", ram_we_o, exp_we);
        check_eq("ram_addr", ram_addr_o, exp_addr);
        check_eq("ram_wdata", ram_wdata_o, exp_wdata);
        exp_rv = '0;
        exp_rd = '0;
        exp_busy = (owner >= 0);
        foreach (rq[i]) begin
            if (rq[i].due == cyc) begin
                exp_rv[rq[i].id] = 1'b1;
                exp_rd = rq[i].data;
            end
            if (rq[i].acc + 1 < cyc) exp_busy = 1'b1;
        end
        check_eq("rvalid", rvalid_o, exp_rv);
        if (exp_rv != '0) check_eq("rdata", rdata_o, exp_rd);
        check_eq("busy", busy_o, exp_busy);
        seen_gnt = gnt_o;
        seen_rv = rvalid_o;
        seen_rd = rdata_o;
        seen_en = ram_en_o;
        seen_we = ram_we_o;
        seen_busy = busy_o;
        s_en = ram_en_o;
        s_we = ram_we_o;
        s_addr = ram_addr_o;
        s_wdata = ram_wdata_o;
    endtask

    task automatic model_update();
        int k;
        if (saved_gnt != '0) begin
            k = 0;
            for (int i = 0; i < N; i++) if (saved_gnt[i]) k = i;
            exp_en = 1'b1;
            exp_we = we_i[k];
            exp_addr = addr_i[k*AW +: AW];
            exp_wdata = wdata_i[k*DW +: DW];
            if (!we_i[k]) rq.push_back('{cyc + 1 + RDL, cyc, k, ref_mem[exp_addr]});
            else ref_mem[exp_addr] = exp_wdata;
            if (owner < 0) begin
                last_g = k;
                cnt = 1;
                if (lock_i[k] && BMAX > 1) owner = k;
            end else begin
                cnt++;
                if (!lock_i[k] || cnt >= BMAX) owner = -1;
            end
        end else begin
            exp_en = 1'b0;
            if (owner >= 0 && !req_i[owner]) owner = -1;
        end
        while (rq.size() > 0 && rq[0].due <= cyc) void'(rq.pop_front());
    endtask

    // One clock: inputs already driven at posedge+1; check at negedge; advance at posedge.
    task automatic cycle();
        #4;
        check_outputs();
        @(posedge clk);
        if (s_en && s_we) ram_mem[s_addr] = s_wdata;
        for (int i = RDL - 1; i > 0; i--) ram_pipe[i] = ram_pipe[i-1];
        ram_pipe[0] = (s_en && !s_we) ? ram_mem[s_addr] : $urandom;
        ram_rdata_i = ram_pipe[RDL-1];
        if (!rst) model_update();
        cyc++;
        #1;
    endtask

    task automatic drive(input int n, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic lk);
        req_i[n] = 1'b1;
        we_i[n] = we;
        lock_i[n] = lk;
        addr_i[n*AW +: AW] = a;
        wdata_i[n*DW +: DW] = d;
    endtask

    task automatic idle(input int n);
        req_i = '0;
        lock_i = '0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    logic [N-1:0] rr_exp [5];
    logic [N-1:0] lk_exp [6];
    logic [N-1:0] st_exp [8];

    initial begin
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        lk_exp = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0010};
        st_exp = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b1000};
        for (int i = 0; i < DEPTH; i++) begin
            ram_mem[i] = $urandom;
            ref_mem[i] = ram_mem[i];
        end
        ram_mem[5] = 32'hDEADBEEF;
        ref_mem[5] = 32'hDEADBEEF;
        for (int i = 0; i < RDL; i++) ram_pipe[i] = '0;
        rst = 1'b1;
        req_i = '0;
        lock_i = '0;
        we_i = '0;
        addr_i = '0;
        wdata_i = '0;
        ram_ready_i = 1'b1;
        ram_rdata_i = '0;
        cyc = 0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset state.
        cycle();
        check_eq("reset_rdata", seen_rd, '0);
        cycle();
        rst = 1'b0;
        cycle();

        // Round robin with all four requesting.
        for (int i = 0; i < 5; i++) begin
            for (int n = 0; n < N; n++) drive(n, 1'b1, AW'(10'h100 + n), $urandom, 1'b0);
            cycle();
            check_eq("rr_seq", seen_gnt, rr_exp[i]);
        end
        idle(2);

        // Single read of the preloaded word.
        drive(2, 1'b0, 10'h005, '0, 1'b0);
        cycle();
        check_eq("rd_gnt", seen_gnt, 4'b0100);
        req_i = '0;
        cycle();
        check_eq("rd_cmd_en", seen_en, 1'b1);
        check_eq("rd_cmd_we", seen_we, 1'b0);
        cycle();
        cycle();
        check_eq("rd_rvalid", seen_rv, 4'b0100);
        check_eq("rd_rdata", seen_rd, 32'hDEADBEEF);
        idle(2);

        // Locked burst with a competitor.
        for (int i = 0; i < 6; i++) begin
            drive(1, 1'b1, AW'(10'h200 + i), $urandom, 1'b1);
            if (i > 0) drive(3, 1'b1, 10'h300, $urandom, 1'b0);
            cycle();
            check_eq("lock_seq", seen_gnt, lk_exp[i]);
        end
        idle(3);

        // RAM stall in the middle of a locked burst.
        for (int i = 0; i < 8; i++) begin
            drive(1, 1'b1, AW'(10'h210 + i), $urandom, 1'b1);
            if (i > 0) drive(3, 1'b1, 10'h310, $urandom, 1'b0);
            ram_ready_i = !(i >= 2 && i <= 4);
            cycle();
            check_eq("stall_seq", seen_gnt, st_exp[i]);
            if (i == 3) check_eq("stall_busy", seen_busy, 1'b1);
        end
        ram_ready_i = 1'b1;
        idle(3);

        // Back-to-back reads from three requesters.
        for (int n = 0; n < 3; n++) begin
            req_i = '0;
            drive(n, 1'b0, AW'(10'h100 + n), '0, 1'b0);
            cycle();
        end
        req_i = '0;
        for (int n = 0; n < 3; n++) begin
            cycle();
            check_eq("b2b_rvalid", seen_rv, 4'(1 << n));
        end
        idle(2);

        // Reset while a read is in flight.
        drive(0, 1'b0, 10'h005, '0, 1'b0);
        cycle();
        req_i = '0;
        rst = 1'b1;
        model_reset();
        cycle();
        check_eq("rst_en", seen_en, 1'b0);
        check_eq("rst_rdata", seen_rd, '0);
        check_eq("rst_busy", seen_busy, 1'b0);
        cycle();
        rst = 1'b0;
        idle(4);
        for (int n = 0; n < N; n++) drive(n, 1'b1, AW'(10'h120 + n), $urandom, 1'b0);
        cycle();
        check_eq("post_rst_gnt", seen_gnt, 4'b0001);
        idle(2);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            req_i = N'($urandom);
            lock_i = N'($urandom & $urandom);
            we_i = N'($urandom);
            for (int n = 0; n < N; n++) begin
                addr_i[n*AW +: AW] = AW'($urandom_range(0, 31));
                wdata_i[n*DW +: DW] = $urandom;
            end
            ram_ready_i = ($urandom_range(0, 99) < 85);
            cycle();
        end
        ram_ready_i = 1'b1;
        idle(8);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
